pipeline_reg_chain: RTL



---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_stage_reg.sv | 27 ++
 rtl/pipeline_reg_chain.sv | 74 +++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: stage index names, default chain sizes and the hold-vector helper
// shared by the pipeline register chain.
package pipe_pkg;

    typedef enum logic [2:0] {
        STG_F = 3'd0,
        STG_D = 3'd1,
        STG_E = 3'd2,
        STG_M = 3'd3
    } stage_e;

    localparam int PAYLOAD_WIDTH_DEF = 32;
    localparam int NUM_STAGES_DEF    = 4;
    localparam int MAX_STAGES        = 8;

    // A stall on stage k also freezes every earlier stage: hold[k] = |stall[MAX-1:k].
    function automatic logic [MAX_STAGES-1:0] hold_vec(input logic [MAX_STAGES-1:0] stall);
        logic [MAX_STAGES-1:0] h;
        h[MAX_STAGES-1] = stall[MAX_STAGES-1];
        for (int i = MAX_STAGES - 2; i >= 0; i--) h[i] = stall[i] | h[i+1];
        return h;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one valid+payload boundary register with flush, hold, bubble and load;
// an invalid register always holds a zero payload.
module pipe_stage_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic             bubble,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst || flush || (!hold && bubble)) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (!hold) begin
            valid <= load_valid;
            data  <= load_valid ? load_data : '0;
        end
    end

endmodule

// File: rtl/pipeline_reg_chain.sv
// pipeline_reg_chain: NUM_STAGES pipeline registers with stall/flush control and,
// when PIPELINE_REG_CHAIN_PERF_EN is defined, saturating stall/flush/bubble counters.
module pipeline_reg_chain
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = PAYLOAD_WIDTH_DEF,
    parameter int NUM_STAGES    = NUM_STAGES_DEF,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [PAYLOAD_WIDTH-1:0]         in_data,
    output logic                             in_ready,
    input  logic [NUM_STAGES-1:0]            stall,
    input  logic [NUM_STAGES-1:0]            flush,
    output logic [NUM_STAGES-1:0]            stage_valid,
    output logic [NUM_STAGES*PAYLOAD_WIDTH-1:0] stage_data,
    output logic [CNT_WIDTH-1:0]             stall_cycles,
    output logic [CNT_WIDTH-1:0]             flush_events,
    output logic [CNT_WIDTH-1:0]             bubble_cycles
);

    logic [NUM_STAGES-1:0] hold;

    assign hold     = NUM_STAGES'(hold_vec(MAX_STAGES'(stall)));
    assign in_ready = !hold[0];

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic                     up_valid;
        logic [PAYLOAD_WIDTH-1:0] up_data;
        logic                     bubble;
        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
            assign bubble   = 1'b0;
        end else begin : g_body
            // Upstream frozen while this stage moves on: take a bubble.
            assign up_valid = stage_valid[k-1];
            assign up_data  = stage_data[(k-1)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            assign bubble   = hold[k-1];
        end
        pipe_stage_reg #(.WIDTH(PAYLOAD_WIDTH)) u_reg (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush[k]),
            .hold      (hold[k]),
            .bubble    (bubble),
            .load_valid(up_valid),
            .load_data (up_data),
            .valid     (stage_valid[k]),
            .data      (stage_data[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH])
        );
    end

`ifdef PIPELINE_REG_CHAIN_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= '0;
            flush_events  <= '0;
            bubble_cycles <= '0;
        end else begin
            if (|stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (|flush && !(&flush_events)) flush_events <= flush_events + CNT_WIDTH'(1);
            if (!stage_valid[NUM_STAGES-1] && !(&bubble_cycles)) bubble_cycles <= bubble_cycles + CNT_WIDTH'(1);
        end
    end
`else
    assign stall_cycles  = '0;
    assign flush_events  = '0;
    assign bubble_cycles = '0;
`endif

endmodule
